fp_div_normalizer: RTL and testbench

//  Post-divide normalize/round stage for the FP32 divider: consumes the raw quotient (sign, biased

---
 rtl/fp_div_normalizer.sv | 147 ++++++++++++++
 tb/tb_fp_div_normalizer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_normalizer.sv
// fp_div_normalizer: normalizes and RNE-rounds a raw FP32 divider quotient into a packed IEEE-754 single,
// shifting one bit per cycle, with valid/ready handshakes on both sides.
module fp_div_normalizer #(
    parameter int MANT_W = 26,
    parameter int EXP_W  = 10
) (
    input  logic                    control,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              q_special,
    input  logic                    q_sign,
    input  logic signed [EXP_W-1:0] q_exp,
    input  logic [MANT_W-1:0]       q_mant,
    input  logic                    q_sticky,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);
    localparam int XW = EXP_W + 1;
    localparam logic signed [XW-1:0] ONE       = XW'(1);
    localparam logic signed [XW-1:0] FLUSH_LIM = XW'(1 - MANT_W);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'(255);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t                state, state_nx;
    logic                  sign_r, sign_nx;
    logic                  sticky_r, sticky_nx;
    logic signed [XW-1:0]  exp_r, exp_nx;
    logic [MANT_W-1:0]     mant_r, mant_nx;
    logic [31:0]           out_nx;
    logic                  ovf_nx, unf_nx, inx_nx;

    logic                  g, r, l, inc, rnd_inexact;
    logic [24:0]           sig_sum;
    logic [23:0]           sig;
    logic signed [XW-1:0]  exp_rnd;
    logic [7:0]            exp_field;
    logic [31:0]           special_out;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Rounding datapath, only consumed in ROUND.
    always_comb begin
        g           = mant_r[1];
        r           = mant_r[0];
        l           = mant_r[2];
        inc         = g & (r | sticky_r | l);
        rnd_inexact = g | r | sticky_r;
        sig_sum     = {1'b0, mant_r[MANT_W-1:2]} + {24'd0, inc};
        sig         = sig_sum[24] ? sig_sum[24:1] : sig_sum[23:0];
        exp_rnd     = exp_r + (sig_sum[24] ? ONE : '0);
        exp_field   = sig[23] ? exp_rnd[7:0] : 8'd0;
        special_out = q_special == 2'b11 ? 32'h7FC0_0000 :
                      q_special == 2'b10 ? {q_sign, 8'hFF, 23'd0} : {q_sign, 31'd0};
    end

    always_comb begin
        state_nx  = state;
        sign_nx   = sign_r;
        sticky_nx = sticky_r;
        exp_nx    = exp_r;
        mant_nx   = mant_r;
        out_nx    = out;
        ovf_nx    = overflow;
        unf_nx    = underflow;
        inx_nx    = inexact;
        case (state)
            IDLE: if (in_valid) begin
                sign_nx   = q_sign;
                sticky_nx = q_sticky;
                exp_nx    = {q_exp[EXP_W-1], q_exp};
                mant_nx   = q_mant;
                if (q_special != 2'b00 || q_mant == '0) begin
                    out_nx   = special_out;
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                    inx_nx   = 1'b0;
                    state_nx = DONE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: if (exp_r < FLUSH_LIM) begin
                mant_nx   = '0;
                sticky_nx = sticky_r | (|mant_r);
                exp_nx    = ONE;
                state_nx  = ROUND;
            end else if (exp_r < ONE) begin
                mant_nx   = mant_r >> 1;
                sticky_nx = sticky_r | mant_r[0];
                exp_nx    = exp_r + ONE;
            end else if (mant_r[MANT_W-1] || exp_r == ONE) begin
                state_nx = ROUND;
            end else begin
                // Terminates within MANT_W-1 steps: the mantissa is nonzero here.
                mant_nx = mant_r << 1;
                exp_nx  = exp_r - ONE;
            end
            ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    out_nx = {sign_r, 8'hFF, 23'd0};
                    ovf_nx = 1'b1;
                    unf_nx = 1'b0;
                    inx_nx = 1'b1;
                end else begin
                    out_nx = {sign_r, exp_field, sig[22:0]};
                    ovf_nx = 1'b0;
                    unf_nx = exp_field == 8'd0 && rnd_inexact;
                    inx_nx = rnd_inexact;
                end
                state_nx = DONE;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge control) begin
        if (reset) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            sticky_r  <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            state     <= state_nx;
            sign_r    <= sign_nx;
            sticky_r  <= sticky_nx;
            exp_r     <= exp_nx;
            mant_r    <= mant_nx;
            out       <= out_nx;
            overflow  <= ovf_nx;
            underflow <= unf_nx;
            inexact   <= inx_nx;
        end
    end
endmodule

// File: tb/tb_fp_div_normalizer.sv
// tb_fp_div_normalizer: directed and randomized checks of fp_div_normalizer against an arithmetic
// reference model of normalization, RNE rounding, flags and handshake latency.
module tb_fp_div_normalizer;
    logic        control = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  q_special = 2'b00;
    logic        q_sign = 1'b0;
    logic [9:0]  q_exp = '0;
    logic [25:0] q_mant = '0;
    logic        q_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        overflow, underflow, inexact;

    int n_vec = 0;
    int n_err = 0;

    fp_div_normalizer dut (
        .control(control), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .q_special(q_special), .q_sign(q_sign), .q_exp(q_exp), .q_mant(q_mant),
        .q_sticky(q_sticky), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 control = ~control;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: the value a quotient must round to, plus the cycle it should appear on.
    task automatic model(input logic [1:0] sp, input logic s, input int e0, input logic [25:0] m0,
                         input logic st0, output logic [31:0] o, output logic ov, output logic un,
                         output logic ix, output int lat);
        longint m = longint'(m0);
        int     e = e0;
        logic   st = st0;
        int     k = 0;
        longint q;
        logic   g, r;
        ov = 0; un = 0; ix = 0;
        if (sp != 2'b00 || m0 == 0) begin
            o   = sp == 2'b11 ? 32'h7FC00000 : sp == 2'b10 ? {s, 8'hFF, 23'd0} : {s, 31'd0};
            lat = 1;
            return;
        end
        if (e < -25) begin
            st = st | (m != 0);
            m  = 0;
            e  = 1;
        end else if (e < 1) begin
            k  = 1 - e;
            st = st | ((m & ((64'd1 << k) - 1)) != 0);
            m  = m >> k;
            e  = 1;
        end else begin
            while (k < e - 1 && m < (64'd1 << 25)) begin
                m = m << 1;
                k++;
            end
            e = e - k;
        end
        lat = 3 + k;
        q = m >> 2;
        g = m[1];
        r = m[0];
        if (g && (r || st || q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            o  = {s, 8'hFF, 23'd0};
            ov = 1;
            ix = 1;
        end else begin
            logic [7:0] f;
            f  = q >= (64'd1 << 23) ? 8'(e) : 8'd0;
            o  = {s, f, q[22:0]};
            ix = g | r | st;
            un = f == 0 && ix;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] sp, input logic s, input int e,
                       input logic [25:0] m, input logic st, input int hold);
        logic [31:0] eo;
        logic        eov, eun, eix;
        int          elat, lat, w;
        model(sp, s, e, m, st, eo, eov, eun, eix, elat);
        @(negedge control);
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge control);
            w++;
        end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        q_special = sp; q_sign = s; q_exp = 10'(e); q_mant = m; q_sticky = st;
        in_valid = 1'b1;
        @(posedge control);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge control);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".out"}, out, eo);
        check({tag, ".flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, eov, eun, eix});
        for (int i = 0; i < hold; i++) begin
            @(negedge control);
            check({tag, ".stall"}, {out_valid, in_ready, overflow, underflow, inexact, out[26:0]},
                  {1'b1, 1'b0, eov, eun, eix, eo[26:0]});
        end
        out_ready = 1'b1;
        @(posedge control);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge control);
        @(negedge control);
        reset = 1'b0;
        check("reset", {out_valid, in_ready, overflow, underflow, inexact}, 32'b01000);
        check("reset.out", out, 32'd0);

        run("unity", 2'b00, 1'b0, 127, 26'h2000000, 1'b0, 0);
        check("unity.val", out, 32'h3F800000);
        run("lshift1", 2'b00, 1'b0, 128, 26'h1000000, 1'b0, 0);
        check("lshift1.val", out, 32'h3F800000);
        run("carry", 2'b00, 1'b0, 127, {24'hFFFFFF, 2'b10}, 1'b0, 0);
        check("carry.val", {out, inexact}, {32'h40000000, 1'b1});
        run("tie_even", 2'b00, 1'b0, 127, {24'hFFFFFE, 2'b10}, 1'b0, 0);
        check("tie_even.val", {out, inexact}, {32'h3FFFFFFE, 1'b1});
        run("ovf", 2'b00, 1'b0, 255, 26'h2000000, 1'b0, 0);
        check("ovf.val", {out, overflow, inexact}, {32'h7F800000, 2'b11});
        run("subn", 2'b00, 1'b0, 0, 26'h2000000, 1'b0, 0);
        check("subn.val", {out, underflow, inexact}, {32'h00400000, 2'b00});
        run("nan", 2'b11, 1'b1, 5, 26'h123, 1'b0, 0);
        check("nan.val", out, 32'h7FC00000);
        run("ninf", 2'b10, 1'b1, 5, 26'h123, 1'b0, 0);
        check("ninf.val", out, 32'hFF800000);
        run("zero_mant", 2'b00, 1'b1, 100, 26'h0, 1'b1, 0);
        run("flush", 2'b00, 1'b1, -200, 26'h3FFFFFF, 1'b0, 0);
        run("deep_rshift", 2'b00, 1'b0, -25, 26'h3FFFFFF, 1'b0, 0);
        run("max_lshift", 2'b00, 1'b0, 300, 26'h0000001, 1'b0, 0);
        run("stall", 2'b00, 1'b0, 127, 26'h2000000, 1'b0, 5);

        @(negedge control);
        q_special = 2'b00; q_sign = 1'b0; q_exp = 10'd200; q_mant = 26'h1; q_sticky = 1'b0;
        in_valid = 1'b1;
        @(posedge control);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge control);
        reset = 1'b1;
        @(posedge control);
        @(negedge control);
        reset = 1'b0;
        check("midreset", {out_valid, in_ready, overflow, underflow, inexact}, 32'b01000);
        check("midreset.out", out, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge control);
            if (out_valid) seen++;
        end
        check("midreset.stale", 32'(seen), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  sp;
            logic [25:0] m;
            int          e;
            sp = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            case ($urandom_range(0, 3))
                0: e = int'($urandom_range(0, 50)) - 40;
                1: e = int'($urandom_range(100, 160));
                2: e = int'($urandom_range(240, 300));
                default: e = int'($urandom_range(0, 1023)) - 512;
            endcase
            m = 26'($urandom) >> $urandom_range(0, 25);
            run("rand", sp, 1'($urandom), e, m, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
